// File: rtl/arbiter_bram_clint_pkg.sv
// Shared address map, CLINT register offsets, bus request type and byte-merge helper.
package arbiter_bram_clint_pkg;

    localparam logic [31:0] bram_base_addr  = 32'h0000_0000;
    localparam logic [31:0] bram_top_addr   = 32'h0000_4000;
    localparam logic [31:0] clint_base_addr = 32'h0200_0000;
    localparam logic [31:0] clint_top_addr  = 32'h0200_C000;

    localparam int unsigned bram_depth_words = (bram_top_addr - bram_base_addr) >> 2;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_req_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/arbiter_core.sv
// Two-port request arbiter: one pending slot per port, single outstanding request.
module arbiter_core
    import arbiter_bram_clint_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     i_valid,
    input  bus_req_t i_req,
    input  logic     d_valid,
    input  bus_req_t d_req,
    input  logic     rsp_valid,
    output logic     issue_valid,
    output bus_req_t issue_req,
    output logic     i_ready,
    output logic     d_ready
);

    logic     pend_i_vld_q, pend_i_vld_d;
    logic     pend_d_vld_q, pend_d_vld_d;
    bus_req_t pend_i_req_q, pend_i_req_d;
    bus_req_t pend_d_req_q, pend_d_req_d;
    logic     out_q, out_d;
    logic     own_d_q, own_d_d;
    logic     can_issue, sel_pd, sel_ld, sel_pi, sel_li;

    // Choose the next request (data before instr, pending before live) and park the loser
    always_comb begin
        can_issue = ~reset & (~out_q | rsp_valid);
        sel_pd = can_issue & pend_d_vld_q;
        sel_ld = can_issue & ~pend_d_vld_q & d_valid;
        sel_pi = can_issue & ~pend_d_vld_q & ~d_valid & pend_i_vld_q;
        sel_li = can_issue & ~pend_d_vld_q & ~d_valid & ~pend_i_vld_q & i_valid;
        issue_valid = sel_pd | sel_ld | sel_pi | sel_li;

        issue_req = i_req;
        if (sel_pd)      issue_req = pend_d_req_q;
        else if (sel_ld) issue_req = d_req;
        else if (sel_pi) issue_req = pend_i_req_q;

        pend_d_vld_d = pend_d_vld_q & ~sel_pd;
        pend_d_req_d = pend_d_req_q;
        if (d_valid && !sel_ld) begin
            pend_d_vld_d = 1'b1;
            pend_d_req_d = d_req;
        end

        pend_i_vld_d = pend_i_vld_q & ~sel_pi;
        pend_i_req_d = pend_i_req_q;
        if (i_valid && !sel_li) begin
            pend_i_vld_d = 1'b1;
            pend_i_req_d = i_req;
        end

        out_d   = issue_valid | (out_q & ~rsp_valid);
        own_d_d = issue_valid ? (sel_pd | sel_ld) : own_d_q;

        // A response in a reset cycle belongs to a dropped transaction
        i_ready = ~reset & out_q & rsp_valid & ~own_d_q;
        d_ready = ~reset & out_q & rsp_valid & own_d_q;
    end

    // Control state: pending flags, outstanding flag and owner
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_i_vld_q <= 1'b0;
            pend_d_vld_q <= 1'b0;
            out_q        <= 1'b0;
            own_d_q      <= 1'b0;
        end else begin
            pend_i_vld_q <= pend_i_vld_d;
            pend_d_vld_q <= pend_d_vld_d;
            out_q        <= out_d;
            own_d_q      <= own_d_d;
        end
    end

    // Pending payloads are only meaningful while their flag is set, so they skip reset
    always_ff @(posedge clock) begin
        pend_i_req_q <= pend_i_req_d;
        pend_d_req_q <= pend_d_req_d;
    end

endmodule

// File: rtl/bram_mem.sv
// Byte-writable single-port block RAM with a registered read port.
module bram_mem #(
    parameter int unsigned DEPTH = 4096
)(
    input  logic                     clock,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    output logic [31:0]              rdata_q
);

    logic [31:0] mem [DEPTH];

    // Lane-masked write and synchronous read of the addressed word
    always_ff @(posedge clock) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
            rdata_q <= mem[idx];
        end
    end

endmodule

// File: rtl/clint_regs.sv
// CLINT: msip bit, 64-bit mtimecmp and a prescaled 64-bit mtime counter.
module clint_regs
    import arbiter_bram_clint_pkg::*;
#(
    parameter int unsigned RTC_DIV = 1
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [13:0] word_off,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata_q,
    output logic        msip,
    output logic        mtip,
    output logic [63:0] mtime
);

    localparam int DIV_W = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;

    logic             msip_q, msip_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      rdata_d;
    logic             wr, tick;

    // Register access decode; a software mtime write overrides that cycle's increment
    always_comb begin
        wr    = en & (|wstrb);
        tick  = (div_q == DIV_W'(RTC_DIV - 1));
        div_d = tick ? '0 : div_q + DIV_W'(1);

        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        rdata_d    = rdata_q;

        if (en) begin
            rdata_d = '0;
            case (word_off)
                CLINT_MSIP[15:2]: begin
                    if (!wr)           rdata_d = {31'd0, msip_q};
                    else if (wstrb[0]) msip_d  = wdata[0];
                end
                CLINT_MTIMECMP_LO[15:2]: begin
                    if (!wr) rdata_d = mtimecmp_q[31:0];
                    else     mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wdata, wstrb);
                end
                CLINT_MTIMECMP_HI[15:2]: begin
                    if (!wr) rdata_d = mtimecmp_q[63:32];
                    else     mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata, wstrb);
                end
                CLINT_MTIME_LO[15:2]: begin
                    if (!wr) rdata_d = mtime_q[31:0];
                    else     mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata, wstrb)};
                end
                CLINT_MTIME_HI[15:2]: begin
                    if (!wr) rdata_d = mtime_q[63:32];
                    else     mtime_d = {merge_bytes(mtime_q[63:32], wdata, wstrb), mtime_q[31:0]};
                end
                default: ;
            endcase
        end
    end

    // CLINT state update
    always_ff @(posedge clock) begin
        if (reset) begin
            msip_q     <= 1'b0;
            mtimecmp_q <= '1;
            mtime_q    <= '0;
            div_q      <= '0;
            rdata_q    <= '0;
        end else begin
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            mtime_q    <= mtime_d;
            div_q      <= div_d;
            rdata_q    <= rdata_d;
        end
    end

    assign msip  = msip_q;
    assign mtime = mtime_q;
    assign mtip  = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/arbiter_bram_clint.sv
// Memory subsystem top: arbitrates fetch/data ports, decodes to BRAM or CLINT, muxes the response.
module arbiter_bram_clint
    import arbiter_bram_clint_pkg::*;
#(
    parameter logic [31:0] BRAM_BASE  = bram_base_addr,
    parameter int unsigned BRAM_DEPTH = bram_depth_words,
    parameter logic [31:0] CLINT_BASE = clint_base_addr,
    parameter int unsigned RTC_DIV    = 1
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        imemory_valid,
    input  logic        imemory_instr,
    input  logic [31:0] imemory_addr,
    input  logic [31:0] imemory_wdata,
    input  logic [3:0]  imemory_wstrb,
    output logic [31:0] imemory_rdata,
    output logic        imemory_ready,
    input  logic        dmemory_valid,
    input  logic        dmemory_instr,
    input  logic [31:0] dmemory_addr,
    input  logic [31:0] dmemory_wdata,
    input  logic [3:0]  dmemory_wstrb,
    output logic [31:0] dmemory_rdata,
    output logic        dmemory_ready,
    output logic        msip,
    output logic        mtip,
    output logic [63:0] mtime
);

    localparam int unsigned AW          = $clog2(BRAM_DEPTH);
    localparam logic [31:0] BRAM_BYTES  = 32'(4 * BRAM_DEPTH);
    localparam logic [31:0] CLINT_BYTES = clint_top_addr - clint_base_addr;

    bus_req_t    i_req, d_req, issue_req;
    logic        issue_valid;
    logic [31:0] bram_off, clint_off, bram_rdata, clint_rdata, rsp_rdata;
    logic        in_bram, in_clint, bram_en, clint_en;
    logic        resp_q, resp_d, sel_bram_q, sel_bram_d, sel_clint_q, sel_clint_d, wr_q, wr_d;
    logic        unused_instr;

    assign unused_instr = imemory_instr ^ dmemory_instr;

    // Pack port signals into request structs
    always_comb begin
        i_req.addr  = imemory_addr;
        i_req.wdata = imemory_wdata;
        i_req.wstrb = imemory_wstrb;
        d_req.addr  = dmemory_addr;
        d_req.wdata = dmemory_wdata;
        d_req.wstrb = dmemory_wstrb;
    end

    arbiter_core u_arb (
        .clock       (clock),
        .reset       (reset),
        .i_valid     (imemory_valid),
        .i_req       (i_req),
        .d_valid     (dmemory_valid),
        .d_req       (d_req),
        .rsp_valid   (resp_q),
        .issue_valid (issue_valid),
        .issue_req   (issue_req),
        .i_ready     (imemory_ready),
        .d_ready     (dmemory_ready)
    );

    // Window decode on offsets (unsigned wrap rejects addresses below the base) and response mux
    always_comb begin
        bram_off  = issue_req.addr - BRAM_BASE;
        clint_off = issue_req.addr - CLINT_BASE;
        in_bram   = (bram_off < BRAM_BYTES);
        in_clint  = (clint_off < CLINT_BYTES) & ~in_bram;
        bram_en   = issue_valid & in_bram;
        clint_en  = issue_valid & in_clint;

        resp_d      = issue_valid;
        sel_bram_d  = in_bram;
        sel_clint_d = in_clint;
        wr_d        = |issue_req.wstrb;

        rsp_rdata = '0;
        if (!wr_q) begin
            if (sel_bram_q)       rsp_rdata = bram_rdata;
            else if (sel_clint_q) rsp_rdata = clint_rdata;
        end
        imemory_rdata = imemory_ready ? rsp_rdata : '0;
        dmemory_rdata = dmemory_ready ? rsp_rdata : '0;
    end

    // Response tracking for the request issued last cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_q      <= 1'b0;
            sel_bram_q  <= 1'b0;
            sel_clint_q <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            resp_q      <= resp_d;
            sel_bram_q  <= sel_bram_d;
            sel_clint_q <= sel_clint_d;
            wr_q        <= wr_d;
        end
    end

    bram_mem #(.DEPTH(BRAM_DEPTH)) u_bram (
        .clock   (clock),
        .en      (bram_en),
        .idx     (bram_off[AW+1:2]),
        .wdata   (issue_req.wdata),
        .wstrb   (issue_req.wstrb),
        .rdata_q (bram_rdata)
    );

    clint_regs #(.RTC_DIV(RTC_DIV)) u_clint (
        .clock    (clock),
        .reset    (reset),
        .en       (clint_en),
        .word_off (clint_off[15:2]),
        .wdata    (issue_req.wdata),
        .wstrb    (issue_req.wstrb),
        .rdata_q  (clint_rdata),
        .msip     (msip),
        .mtip     (mtip),
        .mtime    (mtime)
    );

endmodule

// File: tb/tb_arbiter_bram_clint.sv
// Directed bench for arbiter_bram_clint: BRAM, arbitration, CLINT timer/msip, decode edges, reset.
module tb_arbiter_bram_clint;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imemory_valid = 1'b0, imemory_instr = 1'b0;
    logic [31:0] imemory_addr = '0, imemory_wdata = '0;
    logic [3:0]  imemory_wstrb = '0;
    logic [31:0] imemory_rdata;
    logic        imemory_ready;
    logic        dmemory_valid = 1'b0, dmemory_instr = 1'b0;
    logic [31:0] dmemory_addr = '0, dmemory_wdata = '0;
    logic [3:0]  dmemory_wstrb = '0;
    logic [31:0] dmemory_rdata;
    logic        dmemory_ready;
    logic        msip, mtip;
    logic [63:0] mtime;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] tb_cyc = '0;

    arbiter_bram_clint dut (
        .clock         (clock),
        .reset         (reset),
        .imemory_valid (imemory_valid),
        .imemory_instr (imemory_instr),
        .imemory_addr  (imemory_addr),
        .imemory_wdata (imemory_wdata),
        .imemory_wstrb (imemory_wstrb),
        .imemory_rdata (imemory_rdata),
        .imemory_ready (imemory_ready),
        .dmemory_valid (dmemory_valid),
        .dmemory_instr (dmemory_instr),
        .dmemory_addr  (dmemory_addr),
        .dmemory_wdata (dmemory_wdata),
        .dmemory_wstrb (dmemory_wstrb),
        .dmemory_rdata (dmemory_rdata),
        .dmemory_ready (dmemory_ready),
        .msip          (msip),
        .mtip          (mtip),
        .mtime         (mtime)
    );

    always #5 clock = ~clock;

    // Cycles elapsed since reset deassertion (expected mtime with RTC_DIV = 1)
    always @(posedge clock) begin
        if (reset) tb_cyc <= '0;
        else       tb_cyc <= tb_cyc + 64'd1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One request on the chosen port; called at a negedge, returns two negedges later
    task automatic xfer(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] exp, input string tag);
        if (is_d) begin
            dmemory_valid = 1'b1; dmemory_instr = 1'b0;
            dmemory_addr = addr; dmemory_wdata = wdata; dmemory_wstrb = wstrb;
        end else begin
            imemory_valid = 1'b1; imemory_instr = 1'b1;
            imemory_addr = addr; imemory_wdata = wdata; imemory_wstrb = wstrb;
        end
        @(negedge clock);
        dmemory_valid = 1'b0;
        imemory_valid = 1'b0;
        if (is_d) begin
            chk({tag, "_rdy"}, dmemory_ready, 1);
            chk({tag, "_data"}, dmemory_rdata, exp);
            chk({tag, "_other_rdy"}, imemory_ready, 0);
        end else begin
            chk({tag, "_rdy"}, imemory_ready, 1);
            chk({tag, "_data"}, imemory_rdata, exp);
            chk({tag, "_other_rdy"}, dmemory_ready, 0);
        end
        @(negedge clock);
        chk({tag, "_pulse_end"}, is_d ? dmemory_ready : imemory_ready, 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_i_rdy", imemory_ready, 0);
        chk("rst_d_rdy", dmemory_ready, 0);
        chk("rst_i_data", imemory_rdata, 0);
        chk("rst_d_data", dmemory_rdata, 0);
        chk("rst_msip", msip, 0);
        chk("rst_mtime", mtime, 0);
        chk("rst_mtip", mtip, 0);
        reset = 1'b0;

        // mtime counts cycles since reset release; read issued in cycle 3
        repeat (3) @(negedge clock);
        chk("mtime_port", mtime, 64'd3);
        xfer(1'b1, 32'h0200_BFF8, 32'h0, 4'h0, 32'd3, "mtime_lo_rd");
        xfer(1'b1, 32'h0200_4000, 32'd20, 4'hF, 32'h0, "cmp_lo_wr");
        xfer(1'b1, 32'h0200_4004, 32'd0, 4'hF, 32'h0, "cmp_hi_wr");
        for (int k = 0; k < 20; k++) begin
            chk("mtime_track", mtime, tb_cyc);
            chk("mtip_track", mtip, (tb_cyc >= 64'd20) ? 64'd1 : 64'd0);
            @(negedge clock);
        end
        chk("mtip_held", mtip, 1);
        xfer(1'b1, 32'h0200_4000, 32'h0, 4'h0, 32'd20, "cmp_lo_rd");

        // BRAM full and partial writes
        xfer(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, "wr100");
        xfer(1'b1, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, "rd100");
        xfer(1'b1, 32'h0000_0100, 32'h0000_00AA, 4'h1, 32'h0, "wr100_b0");
        xfer(1'b1, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEAA, "rd100_b0");
        xfer(1'b0, 32'h0000_0104, 32'hCAFE_F00D, 4'hF, 32'h0, "iwr104");

        // Simultaneous requests: data wins, fetch follows one cycle later
        imemory_valid = 1'b1; imemory_instr = 1'b1; imemory_addr = 32'h104; imemory_wstrb = 4'h0;
        dmemory_valid = 1'b1; dmemory_instr = 1'b0; dmemory_addr = 32'h100; dmemory_wstrb = 4'h0;
        @(negedge clock);
        imemory_valid = 1'b0;
        dmemory_valid = 1'b0;
        chk("both_d_rdy", dmemory_ready, 1);
        chk("both_d_data", dmemory_rdata, 32'hDEAD_BEAA);
        chk("both_i_rdy_early", imemory_ready, 0);
        chk("both_i_data_early", imemory_rdata, 0);
        @(negedge clock);
        chk("both_i_rdy", imemory_ready, 1);
        chk("both_i_data", imemory_rdata, 32'hCAFE_F00D);
        chk("both_d_rdy_late", dmemory_ready, 0);
        chk("both_d_data_late", dmemory_rdata, 0);
        @(negedge clock);
        chk("both_idle_i", imemory_ready, 0);
        chk("both_idle_d", dmemory_ready, 0);

        // msip set/clear
        xfer(1'b1, 32'h0200_0000, 32'h1, 4'hF, 32'h0, "msip_set");
        chk("msip_1", msip, 1);
        xfer(1'b1, 32'h0200_0000, 32'h0, 4'h0, 32'h1, "msip_rd");
        xfer(1'b1, 32'h0200_0000, 32'h0, 4'hF, 32'h0, "msip_clr");
        chk("msip_0", msip, 0);

        // Decode boundaries: unmapped accesses must not alias into the RAM
        xfer(1'b1, 32'h8000_0000, 32'h0, 4'h0, 32'h0, "unmapped_rd");
        xfer(1'b1, 32'h0000_0000, 32'h1111_1111, 4'hF, 32'h0, "wr0");
        xfer(1'b1, 32'h0000_4000, 32'h2222_2222, 4'hF, 32'h0, "wr4000_unmapped");
        xfer(1'b1, 32'h8000_0100, 32'h4444_4444, 4'hF, 32'h0, "wr_unmapped_hi");
        xfer(1'b1, 32'h0000_0000, 32'h0, 4'h0, 32'h1111_1111, "rd0");
        xfer(1'b1, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEAA, "rd100_again");
        xfer(1'b1, 32'h0000_3FFC, 32'h3333_3333, 4'hF, 32'h0, "wr_last");
        xfer(1'b0, 32'h0000_3FFE, 32'h0, 4'h0, 32'h3333_3333, "rd_last_lowbits");
        xfer(1'b1, 32'h0000_4000, 32'h0, 4'h0, 32'h0, "rd4000_unmapped");

        // Reset in the issue cycle drops the transaction
        dmemory_valid = 1'b1; dmemory_addr = 32'h100; dmemory_wstrb = 4'h0;
        reset = 1'b1;
        @(negedge clock);
        dmemory_valid = 1'b0;
        reset = 1'b0;
        chk("rst_mid_rdy", dmemory_ready, 0);
        chk("rst_mid_data", dmemory_rdata, 0);
        chk("rst_mid_mtime", mtime, 0);
        @(negedge clock);
        chk("rst_mid_rdy_late", dmemory_ready, 0);
        xfer(1'b1, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEAA, "rd_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
